// File: rtl/expr_pkg.sv
// Shared definitions for the expression sequencer.
//   state_t      : sequencer states (2-bit encoding)
//   CH_*         : ASCII codes of the characters the grammar cares about
//   char_class_t : classification of one input character
// Optional feature macro used by the top: EXPR_SUB_EN (binary "-" operator).
package expr_pkg;

  typedef enum logic [1:0] {
    EXP_DIGIT = 2'd0,
    EXP_OP    = 2'd1,
    ERR       = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  typedef enum logic [2:0] {
    CL_DIGIT = 3'd0,
    CL_PLUS  = 3'd1,
    CL_MUL   = 3'd2,
    CL_EQ    = 3'd3,
    CL_MINUS = 3'd4,
    CL_ILL   = 3'd5
  } char_class_t;

endpackage

// File: rtl/expr_char_class.sv
// Combinational character classifier for the expression sequencer.
// Ports:
//   ch    in  8  ASCII character
//   cls   out    character class (char_class_t)
//   digit out 4  numeric value when cls == CL_DIGIT, otherwise 0
// "-" is always reported as CL_MINUS; whether it is legal is decided by the
// top level (EXPR_SUB_EN).
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0]  ch,
  output char_class_t cls,
  output logic [3:0]  digit
);

  always_comb begin
    cls   = CL_ILL;
    digit = 4'd0;
    if (ch >= CH_0 && ch <= CH_9) begin
      cls   = CL_DIGIT;
      // '0'..'9' are 0x30..0x39, so the low nibble is the value.
      digit = ch[3:0];
    end else begin
      case (ch)
        CH_PLUS:  cls = CL_PLUS;
        CH_MUL:   cls = CL_MUL;
        CH_EQ:    cls = CL_EQ;
        CH_MINUS: cls = CL_MINUS;
        default:  cls = CL_ILL;
      endcase
    end
  end

endmodule

// File: rtl/expr_seq_ctrl.sv
// Expression sequencer: consumes an ASCII stream of the form
// digit (op digit)* "=" and evaluates it with "*" binding tighter than "+".
// All arithmetic wraps modulo 2^W.
// Ports:
//   clk        in  1  clock
//   clr        in  1  synchronous active-high reset
//   in_valid   in  1  in_char is valid
//   in_char    in  8  ASCII character
//   in_ready   out 1  character accepted this cycle (state != DONE)
//   res_valid  out 1  result/err valid
//   res_ready  in  1  consumer takes the result
//   result     out W  expression value, 0 when err=1
//   err        out 1  malformed or over-long expression
// Optional feature: define EXPR_SUB_EN to accept "-" as a binary operator
// (two's complement result). Without it "-" is an illegal character.
module expr_seq_ctrl
  import expr_pkg::*;
#(
  parameter int W       = 16,
  parameter int MAX_LEN = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in_char,
  output logic         in_ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         err
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_t           state;
  logic [W-1:0]     sum;
  logic [W-1:0]     term;
  logic             mul_pend;
  logic [LEN_W-1:0] len;
`ifdef EXPR_SUB_EN
  logic             neg;
`endif

  char_class_t  cls;
  logic [3:0]   digit;
  logic [W-1:0] dval;
  logic         too_long;

  expr_char_class u_class (
    .ch    (in_char),
    .cls   (cls),
    .digit (digit)
  );

  assign dval     = W'(digit);
  assign in_ready = (state != DONE);
  // len already holds MAX_LEN chars, so the one being accepted is one too many.
  assign too_long = (len == LEN_W'(MAX_LEN));

  // Value loaded into term when a digit starts a new product.
  function automatic logic [W-1:0] first_factor(input logic [W-1:0] d,
                                                input logic          is_neg);
    first_factor = is_neg ? ('0 - d) : d;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= EXP_DIGIT;
      sum       <= '0;
      term      <= '0;
      mul_pend  <= 1'b0;
      len       <= '0;
      result    <= '0;
      err       <= 1'b0;
      res_valid <= 1'b0;
`ifdef EXPR_SUB_EN
      neg       <= 1'b0;
`endif
    end else if (state == DONE) begin
      // Result is held until the consumer takes it; no char is accepted here.
      if (res_ready) begin
        sum       <= '0;
        term      <= '0;
        mul_pend  <= 1'b0;
        len       <= '0;
        res_valid <= 1'b0;
`ifdef EXPR_SUB_EN
        neg       <= 1'b0;
`endif
        state     <= EXP_DIGIT;
      end
    end else if (in_valid) begin
      // Saturates at MAX_LEN: anything beyond is already an error.
      if (!too_long) len <= len + 1'b1;

      if (too_long) begin
        if (cls == CL_EQ) begin
          state     <= DONE;
          err       <= 1'b1;
          result    <= '0;
          res_valid <= 1'b1;
        end else begin
          state <= ERR;
        end
      end else begin
        case (state)
          EXP_DIGIT: begin
            case (cls)
              CL_DIGIT: begin
`ifdef EXPR_SUB_EN
                term <= mul_pend ? term * dval : first_factor(dval, neg);
`else
                term <= mul_pend ? term * dval : first_factor(dval, 1'b0);
`endif
                state <= EXP_OP;
              end
              CL_EQ: begin
                // Empty expression or trailing operator.
                state     <= DONE;
                err       <= 1'b1;
                result    <= '0;
                res_valid <= 1'b1;
              end
              default: state <= ERR;
            endcase
          end
          EXP_OP: begin
            case (cls)
              CL_PLUS: begin
                sum      <= sum + term;
                mul_pend <= 1'b0;
`ifdef EXPR_SUB_EN
                neg      <= 1'b0;
`endif
                state    <= EXP_DIGIT;
              end
              CL_MUL: begin
                mul_pend <= 1'b1;
                state    <= EXP_DIGIT;
              end
`ifdef EXPR_SUB_EN
              CL_MINUS: begin
                // The sign rides on term, so a following "*" keeps it.
                sum      <= sum + term;
                mul_pend <= 1'b0;
                neg      <= 1'b1;
                state    <= EXP_DIGIT;
              end
`endif
              CL_EQ: begin
                result    <= sum + term;
                err       <= 1'b0;
                res_valid <= 1'b1;
                state     <= DONE;
              end
              default: state <= ERR;
            endcase
          end
          ERR: begin
            if (cls == CL_EQ) begin
              state     <= DONE;
              err       <= 1'b1;
              result    <= '0;
              res_valid <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_expr_seq_ctrl.sv
// Directed bench for expr_seq_ctrl (W=8, MAX_LEN=8) with a result scoreboard.
module tb_expr_seq_ctrl;

  localparam int W       = 8;
  localparam int MAX_LEN = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         in_valid;
  logic [7:0]   in_char;
  logic         in_ready;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         err;

  typedef struct packed {
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  expr_seq_ctrl #(.W(W), .MAX_LEN(MAX_LEN)) u_dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    int n = 0;
    in_valid = 1'b1;
    in_char  = c;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic push_exp(input logic [W-1:0] r, input logic e);
    exp_t x;
    x.res = r;
    x.err = e;
    sb.push_back(x);
  endtask

  // Wait for a result, compare it to the oldest expectation, then hand it off.
  task automatic collect(input string tag);
    int   n = 0;
    exp_t x;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'b0, res_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      x = sb.pop_front();
      chk({tag, "_result"}, {24'b0, result}, {24'b0, x.res});
      chk({tag, "_err"}, {31'b0, err}, {31'b0, x.err});
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_valid_drop"}, {31'b0, res_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    clr       = 1'b1;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_result", {24'b0, result}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);

    // Precedence and first-result latency.
    push_exp(8'd7, 1'b0);
    send_str("1+2*3=");
    chk("lat_res_valid", {31'b0, res_valid}, 32'd1);
    chk("done_in_ready", {31'b0, in_ready}, 32'd0);
    collect("prec");

    push_exp(8'd29, 1'b0);
    send_str("2*3*4+5=");
    collect("chain");

    // 729 mod 256
    push_exp(8'd217, 1'b0);
    send_str("9*9*9=");
    collect("wrap");

    push_exp(8'd0, 1'b1);
    send_str("1++2=");
    collect("dbl_op");

    push_exp(8'd0, 1'b1);
    send_str("=");
    collect("empty");

    push_exp(8'd7, 1'b0);
    send_str("7=");
    collect("single");

    push_exp(8'd0, 1'b1);
    send_str("1+a=");
    collect("illegal");

    push_exp(8'd0, 1'b1);
    send_str("3*=");
    collect("trail_op");

    // Back-pressure: result held, char offered during DONE is not taken.
    push_exp(8'd9, 1'b0);
    send_str("3*3=");
    in_valid = 1'b1;
    in_char  = "5";
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_result", {24'b0, result}, 32'd9);
      chk("hold_valid", {31'b0, res_valid}, 32'd1);
    end
    collect("hold");
    push_exp(8'd7, 1'b0);
    send_str("7=");
    collect("after_hold");

    // clr mid-expression discards the partial product.
    send_str("4*");
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_mid_ready", {31'b0, in_ready}, 32'd1);
    chk("clr_mid_valid", {31'b0, res_valid}, 32'd0);
    push_exp(8'd5, 1'b0);
    send_str("5=");
    collect("clr_mid");

    // clr during DONE drops the pending result.
    send_str("2+2=");
    chk("pre_clr_valid", {31'b0, res_valid}, 32'd1);
    chk("pre_clr_result", {24'b0, result}, 32'd4);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_done_valid", {31'b0, res_valid}, 32'd0);
    chk("clr_done_result", {24'b0, result}, 32'd0);
    chk("clr_done_ready", {31'b0, in_ready}, 32'd1);

    // Length limit: exactly MAX_LEN chars is fine, one more is an error.
    push_exp(8'd10, 1'b0);
    send_str("1+2+3+4=");
    collect("len_max");
    push_exp(8'd0, 1'b1);
    send_str("1+2+3+4*5=");
    collect("len_over");
    push_exp(8'd3, 1'b0);
    send_str("1+2=");
    collect("len_recover");

`ifdef EXPR_SUB_EN
    push_exp(8'hFB, 1'b0);
`else
    push_exp(8'd0, 1'b1);
`endif
    send_str("1-2*3=");
    collect("minus");

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
